stream_mux_n_to_1: RTL
======================

// Module: stream_mux_n_to_1
// PURPOSE
//  Parametrised N:1 datapath source selector with a registered output and valid/ready handshake.
//  Sits between datapath producers (ALU, shifter, memory read, immediate path, ...) and the
//  register-file write port. Two runtime modes:
//    - DIRECT: select by index.
//    - ROUND-ROBIN: fair arbitration among valid producers.
//  Also reports which source won, and flags out-of-range selects.
// PARAMETERS
//  WIDTH   32  data width per input and output
//  NUM_IN  8   number of inputs (2..16; need not be a power of 2)
//  SEL_W   3   select width; must equal $clog2(NUM_IN)
// PORTS
//  clk        in   1             single clock; all state on rising edge
//  rst_n      in   1             synchronous, active-low reset
//  in_data    in   NUM_IN*WIDTH  packed inputs; input k = in_data[k*WIDTH +: WIDTH]
//  in_valid   in   NUM_IN        per-input valid
//  in_ready   out  NUM_IN        per-input ready (combinational); at most one bit high
//  sel        in   SEL_W         input index used in DIRECT mode
//  mode       in   1             0 = DIRECT, 1 = ROUND-ROBIN
//  out_data   out  WIDTH         registered selected data
//  out_src    out  SEL_W         registered index of the input that supplied out_data
//  out_valid  out  1             out_data/out_src hold a valid beat
//  out_ready  in   1             consumer accepts the beat when out_valid && out_ready
//  sel_err    out  1             registered 1-cycle pulse: DIRECT mode with sel >= NUM_IN
// BEHAVIOUR
//  Clock/reset: one clock; reset is synchronous and active-low.
//  Reset values (while rst_n=0 at a clk edge): out_valid=0, out_data=0, out_src=0,
//   sel_err=0, rr_ptr=0. in_ready is all-0 during reset.
//  Load enable: load_en = !out_valid || out_ready. The single output register may refill in
//   the same cycle it drains; 100% throughput, no bubble.
//  Candidate selection (combinational, from this cycle's mode/sel/in_valid):
//   DIRECT: cand = sel; hit = (sel < NUM_IN) && in_valid[sel].
//   ROUND-ROBIN: cand = first k in order rr_ptr, rr_ptr+1, ... (mod NUM_IN) with in_valid[k];
//    hit = |in_valid. sel is ignored.
//  in_ready[cand] = load_en && hit (only when cand < NUM_IN); all other bits 0.
//   A producer transfers when in_valid[k] && in_ready[k].
//  On a clk edge with load_en:
//   hit: out_data <= input cand, out_src <= cand, out_valid <= 1.
//   !hit: out_valid <= 0; out_data and out_src hold their values.
//  Without load_en (out_valid && !out_ready): out_data, out_src, out_valid all hold.
//   mode, sel and in_valid changes have no effect on the held beat.
//  Latency: input accepted at edge t -> visible on out_* after edge t (1 cycle).
//  rr_ptr: updates only on an input transfer in ROUND-ROBIN mode: rr_ptr <= (cand+1) mod NUM_IN,
//   wrapping NUM_IN-1 -> 0. DIRECT-mode transfers leave rr_ptr unchanged.
//  sel_err: high for exactly the cycle after any edge where mode=0 && sel >= NUM_IN,
//   regardless of load_en. No transfer occurs on such a cycle.
//  Mode switch: takes effect on the same cycle's selection. Any in-flight output beat is
//   unaffected.
//  Reset mid-stream: a pending out beat is discarded (out_valid=0) and no in_ready is asserted.
// TESTING
//  T1 DIRECT, NUM_IN=8: sel=5, in5=0xDEADBEEF valid, out_ready=1
//     -> in_ready=8'b0010_0000; next cycle out_data=0xDEADBEEF, out_src=5, out_valid=1.
//  T2 Backpressure: beat 0x11 held with out_ready=0 for 3 cycles while sel changes 5->2
//     -> out_data stays 0x11, in_ready=0. out_ready=1 -> in2 loads on that same edge (no bubble).
//  T3 ROUND-ROBIN: all 8 valid, out_ready=1 for 10 cycles
//     -> out_src = 0,1,...,7,0,1 in order; rr_ptr wraps 7->0.
//  T4 ROUND-ROBIN sparse: rr_ptr=6, only in_valid[1] and in_valid[3] set
//     -> grant 1, then rr_ptr=2 -> grant 3 on the next cycle.
//  T5 NUM_IN=6, SEL_W=3, DIRECT, sel=7 -> in_ready=0, sel_err pulses 1 cycle, out_valid falls to 0.
//  T6 Reset: assert rst_n=0 while out_valid=1, out_ready=0
//     -> after the edge out_valid=0, out_data=0, out_src=0, rr_ptr=0.
//     Then run a ROUND-ROBIN sequence -> first grant searches from index 0.

Source files
------------

// File: rtl/stream_mux_n_to_1.sv
// stream_mux_n_to_1: N:1 stream selector (direct or round-robin) with registered output and valid/ready handshake
module stream_mux_n_to_1 #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 8,
  parameter int SEL_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    mode,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);
  logic [WIDTH-1:0] out_data_q, cand_data;
  logic [SEL_W-1:0] out_src_q, rr_ptr_q, rr_ptr_d, cand;
  logic             out_valid_q, sel_err_q, load_en, hit, sel_ok;
  int               best, off;
  assign load_en = !out_valid_q || out_ready;
  assign sel_ok  = 32'(sel) < NUM_IN;
  // Pick this cycle's candidate: the selected index, or the nearest valid input at/after rr_ptr
  always_comb begin
    cand = sel;
    hit  = 1'b0;
    best = NUM_IN;
    off  = 0;
    if (mode) begin
      hit = |in_valid;
      for (int k = 0; k < NUM_IN; k++) begin
        off = k >= int'(rr_ptr_q) ? k - int'(rr_ptr_q) : k + NUM_IN - int'(rr_ptr_q);
        if (in_valid[k] && off < best) begin
          best = off;
          cand = SEL_W'(k);
        end
      end
    end else begin
      for (int k = 0; k < NUM_IN; k++)
        if (sel == SEL_W'(k)) hit = in_valid[k];
    end
  end
  // Steer the winner's data forward and grant ready only to it, never during reset
  always_comb begin
    cand_data = '0;
    in_ready  = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (cand == SEL_W'(k)) cand_data = in_data[k*WIDTH +: WIDTH];
      in_ready[k] = rst_n && load_en && hit && cand == SEL_W'(k);
    end
  end
  assign rr_ptr_d = (mode && load_en && hit) ? (cand == SEL_W'(NUM_IN-1) ? '0 : cand + 1'b1) : rr_ptr_q;
  // Output register refills whenever it is empty or being drained; pointer advances past each RR winner
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      sel_err_q   <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      if (load_en) begin
        out_valid_q <= hit;
        if (hit) begin
          out_data_q <= cand_data;
          out_src_q  <= cand;
        end
      end
      sel_err_q <= !mode && !sel_ok;
      rr_ptr_q  <= rr_ptr_d;
    end
  end
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_valid = out_valid_q;
  assign sel_err   = sel_err_q;
endmodule
